// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle datapath: controller states, opcodes, ALU/mux selects.
// Used by the control FSM, the ALU control decoder and the datapath muxes.
package multicycle_ctrl_pkg;

  localparam int OPC_W   = 6;
  localparam int STATE_W = 4;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_e;

  localparam logic [OPC_W-1:0] OP_R    = 6'b000000;
  localparam logic [OPC_W-1:0] OP_LW   = 6'b100011;
  localparam logic [OPC_W-1:0] OP_SW   = 6'b101011;
  localparam logic [OPC_W-1:0] OP_BEQ  = 6'b000100;
  localparam logic [OPC_W-1:0] OP_ADDI = 6'b001000;
  localparam logic [OPC_W-1:0] OP_J    = 6'b000010;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } alu_op_e;

  typedef enum logic [1:0] {
    SRCB_B      = 2'b00,
    SRCB_FOUR   = 2'b01,
    SRCB_IMM    = 2'b10,
    SRCB_IMM_SH = 2'b11
  } alu_src_b_e;

  typedef enum logic [1:0] {
    PCSRC_ALU    = 2'b00,
    PCSRC_ALUOUT = 2'b01,
    PCSRC_JUMP   = 2'b10
  } pc_src_e;

  typedef struct packed {
    logic       pc_write;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    alu_src_b_e alu_src_b;
    alu_op_e    alu_op;
    pc_src_e    pc_source;
    logic       illegal_op;
  } ctrl_t;

  function automatic logic is_mem_op(input logic [OPC_W-1:0] opc);
    return (opc == OP_LW) || (opc == OP_SW);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath bundle: IR opcode, ALU flag and memory handshake in; enables and selects out.
// master = control FSM, slave = datapath.
interface multicycle_ctrl_if #(
  parameter int OP_W = 6,
  parameter int ST_W = 4
);

  logic [OP_W-1:0] opcode;
  logic            zero;
  logic            mem_ready;

  logic            PCWrite;
  logic            IorD;
  logic            MemRead;
  logic            MemWrite;
  logic            IRWrite;
  logic            MemtoReg;
  logic            RegDst;
  logic            RegWrite;
  logic            ALUSrcA;
  logic [1:0]      ALUSrcB;
  logic [1:0]      ALUOp;
  logic [1:0]      PCSource;
  logic            illegal_op;
  logic [ST_W-1:0] state;

  modport master (
    input  opcode, zero, mem_ready,
    output PCWrite, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst,
           RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, illegal_op, state
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  PCWrite, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst,
           RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, illegal_op, state
  );

endinterface

// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multicycle datapath: 3-5 states per instruction, +1 cycle per mem_ready=0 stall.
// Outputs are Moore except the mem_ready/zero-qualified strobes; everything is held at 0 while rst is low.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int OP_W = OPC_W,
  parameter int ST_W = STATE_W
) (
  input logic            clk,
  input logic            rst,
  multicycle_ctrl_if.master bus
);

  state_e          state_q;
  state_e          state_d;
  ctrl_t           ctrl;
  logic [OP_W-1:0] opc;

  assign opc = bus.opcode;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ctrl    = '0;
    case (state_q)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.ir_write  = bus.mem_ready;
        ctrl.pc_write  = bus.mem_ready;
        if (bus.mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        // Speculative branch target lands in ALUOut for BRANCH to use.
        ctrl.alu_src_b = SRCB_IMM_SH;
        if (is_mem_op(OPC_W'(opc)))        state_d = S_MEMADR;
        else if (opc == OP_W'(OP_R))       state_d = S_EXEC;
        else if (opc == OP_W'(OP_BEQ))     state_d = S_BRANCH;
        else if (opc == OP_W'(OP_ADDI))    state_d = S_ADDIEX;
        else if (opc == OP_W'(OP_J))       state_d = S_JUMP;
        else begin
          state_d         = S_FETCH;
          ctrl.illegal_op = 1'b1;
        end
      end
      S_MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        if (opc == OP_W'(OP_LW))      state_d = S_MEMRD;
        else if (opc == OP_W'(OP_SW)) state_d = S_MEMWR;
        else                          state_d = S_FETCH;
      end
      S_MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
        if (bus.mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        state_d         = S_FETCH;
      end
      S_MEMWR: begin
        ctrl.mem_write = 1'b1;
        ctrl.i_or_d    = 1'b1;
        if (bus.mem_ready) state_d = S_FETCH;
      end
      S_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_B;
        ctrl.alu_op    = ALUOP_FUNCT;
        state_d        = S_ALUWB;
      end
      S_ALUWB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
        state_d        = S_FETCH;
      end
      S_BRANCH: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_B;
        ctrl.alu_op    = ALUOP_SUB;
        ctrl.pc_source = PCSRC_ALUOUT;
        ctrl.pc_write  = bus.zero;
        state_d        = S_FETCH;
      end
      S_ADDIEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        state_d        = S_ADDIWB;
      end
      S_ADDIWB: begin
        ctrl.reg_write = 1'b1;
        state_d        = S_FETCH;
      end
      S_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCSRC_JUMP;
        state_d        = S_FETCH;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
    if (!rst) ctrl = '0;
  end

  assign bus.PCWrite    = ctrl.pc_write;
  assign bus.IorD       = ctrl.i_or_d;
  assign bus.MemRead    = ctrl.mem_read;
  assign bus.MemWrite   = ctrl.mem_write;
  assign bus.IRWrite    = ctrl.ir_write;
  assign bus.MemtoReg   = ctrl.mem_to_reg;
  assign bus.RegDst     = ctrl.reg_dst;
  assign bus.RegWrite   = ctrl.reg_write;
  assign bus.ALUSrcA    = ctrl.alu_src_a;
  assign bus.ALUSrcB    = ctrl.alu_src_b;
  assign bus.ALUOp      = ctrl.alu_op;
  assign bus.PCSource   = ctrl.pc_source;
  assign bus.illegal_op = ctrl.illegal_op;
  assign bus.state      = ST_W'(state_q);

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboarded directed bench for multicycle_ctrl: each driven cycle queues its expected state/outputs,
// a negedge monitor pops and compares.
module tb_multicycle_ctrl;
  import multicycle_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  multicycle_ctrl_if #(.OP_W(6), .ST_W(4)) bus ();
  multicycle_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

  int checks   = 0;
  int failures = 0;

  logic [3:0]  exp_st_q[$];
  logic [16:0] exp_out_q[$];
  string       exp_name_q[$];

  // {PCWrite,IorD,MemRead,MemWrite,IRWrite,MemtoReg,RegDst,RegWrite,ALUSrcA,ALUSrcB,ALUOp,PCSource,illegal_op}
  function automatic logic [16:0] mk(input logic pcw, iord, mrd, mwr, irw, m2r, rdst, rw, srca,
                                     input logic [1:0] srcb, aluop, pcsrc, input logic ill);
    return {pcw, iord, mrd, mwr, irw, m2r, rdst, rw, srca, srcb, aluop, pcsrc, ill};
  endfunction

  logic [16:0] o_zero, o_fetch_go, o_fetch_st, o_decode, o_decode_ill, o_memadr, o_memrd, o_memwb;
  logic [16:0] o_memwr, o_exec, o_aluwb, o_br_t, o_br_nt, o_addiex, o_addiwb, o_jump;

  initial begin
    o_zero       = '0;
    o_fetch_go   = mk(1,0,1,0,1,0,0,0,0,2'b01,2'b00,2'b00,0);
    o_fetch_st   = mk(0,0,1,0,0,0,0,0,0,2'b01,2'b00,2'b00,0);
    o_decode     = mk(0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,0);
    o_decode_ill = mk(0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,1);
    o_memadr     = mk(0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0);
    o_memrd      = mk(0,1,1,0,0,0,0,0,0,2'b00,2'b00,2'b00,0);
    o_memwb      = mk(0,0,0,0,0,1,0,1,0,2'b00,2'b00,2'b00,0);
    o_memwr      = mk(0,1,0,1,0,0,0,0,0,2'b00,2'b00,2'b00,0);
    o_exec       = mk(0,0,0,0,0,0,0,0,1,2'b00,2'b10,2'b00,0);
    o_aluwb      = mk(0,0,0,0,0,0,1,1,0,2'b00,2'b00,2'b00,0);
    o_br_t       = mk(1,0,0,0,0,0,0,0,1,2'b00,2'b01,2'b01,0);
    o_br_nt      = mk(0,0,0,0,0,0,0,0,1,2'b00,2'b01,2'b01,0);
    o_addiex     = mk(0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0);
    o_addiwb     = mk(0,0,0,0,0,0,0,1,0,2'b00,2'b00,2'b00,0);
    o_jump       = mk(1,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b10,0);
  end

  logic [16:0] act_out;
  assign act_out = {bus.PCWrite, bus.IorD, bus.MemRead, bus.MemWrite, bus.IRWrite, bus.MemtoReg,
                    bus.RegDst, bus.RegWrite, bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp, bus.PCSource,
                    bus.illegal_op};

  // Drive one cycle of inputs, queue what the DUT must show during it, then advance past the edge.
  task automatic step(input logic r, input logic [5:0] op, input logic z, input logic mr,
                      input state_e st, input logic [16:0] o, input string name);
    rst           = r;
    bus.opcode    = op;
    bus.zero      = z;
    bus.mem_ready = mr;
    exp_st_q.push_back(4'(st));
    exp_out_q.push_back(o);
    exp_name_q.push_back(name);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (exp_st_q.size() > 0) begin
      logic [3:0]  es;
      logic [16:0] eo;
      string       en;
      es = exp_st_q.pop_front();
      eo = exp_out_q.pop_front();
      en = exp_name_q.pop_front();
      checks++;
      if (bus.state !== es || act_out !== eo) begin
        failures++;
        $display("FAIL %s: got state=%0d out=%b, expected state=%0d out=%b",
                 en, bus.state, act_out, es, eo);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish within time limit");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "timeout");
  end

  initial begin
    bus.opcode    = OP_LW;
    bus.zero      = 1'b0;
    bus.mem_ready = 1'b1;
    rst           = 1'b0;
    @(posedge clk);
    #1;
    step(0, OP_LW, 0, 1, S_FETCH, o_zero, "reset_hold");

    // LW, no stalls: 5 cycles
    step(1, OP_LW, 0, 1, S_FETCH,  o_fetch_go, "lw_fetch");
    step(1, OP_LW, 0, 1, S_DECODE, o_decode,   "lw_decode");
    step(1, OP_LW, 0, 1, S_MEMADR, o_memadr,   "lw_memadr");
    step(1, OP_LW, 0, 1, S_MEMRD,  o_memrd,    "lw_memrd");
    step(1, OP_LW, 0, 1, S_MEMWB,  o_memwb,    "lw_memwb");

    // SW with three stalled MEMWR cycles
    step(1, OP_SW, 0, 1, S_FETCH,  o_fetch_go, "sw_fetch");
    step(1, OP_SW, 0, 1, S_DECODE, o_decode,   "sw_decode");
    step(1, OP_SW, 0, 1, S_MEMADR, o_memadr,   "sw_memadr");
    for (int i = 0; i < 3; i++)
      step(1, OP_SW, 0, 0, S_MEMWR, o_memwr, $sformatf("sw_memwr_stall%0d", i));
    step(1, OP_SW, 0, 1, S_MEMWR,  o_memwr,    "sw_memwr_done");

    // BEQ taken, then not taken
    step(1, OP_BEQ, 1, 1, S_FETCH,  o_fetch_go, "beq_t_fetch");
    step(1, OP_BEQ, 1, 1, S_DECODE, o_decode,   "beq_t_decode");
    step(1, OP_BEQ, 1, 1, S_BRANCH, o_br_t,     "beq_t_branch");
    step(1, OP_BEQ, 0, 1, S_FETCH,  o_fetch_go, "beq_nt_fetch");
    step(1, OP_BEQ, 0, 1, S_DECODE, o_decode,   "beq_nt_decode");
    step(1, OP_BEQ, 0, 1, S_BRANCH, o_br_nt,    "beq_nt_branch");

    // Unsupported opcode
    step(1, 6'b111111, 0, 1, S_FETCH,  o_fetch_go,   "ill_fetch");
    step(1, 6'b111111, 0, 1, S_DECODE, o_decode_ill, "ill_decode");

    // Reset during a stalled MEMRD
    step(1, OP_LW, 0, 1, S_FETCH,  o_fetch_go, "rlw_fetch");
    step(1, OP_LW, 0, 1, S_DECODE, o_decode,   "rlw_decode");
    step(1, OP_LW, 0, 1, S_MEMADR, o_memadr,   "rlw_memadr");
    step(1, OP_LW, 0, 0, S_MEMRD,  o_memrd,    "rlw_memrd_stall");
    step(0, OP_LW, 0, 0, S_MEMRD,  o_zero,     "rlw_rst_in_memrd");
    step(1, OP_J,  0, 0, S_FETCH,  o_fetch_st, "post_rst_fetch_stall");

    // J then ADDI back to back, then an R-type
    step(1, OP_J,    0, 1, S_FETCH,  o_fetch_go, "j_fetch");
    step(1, OP_J,    0, 1, S_DECODE, o_decode,   "j_decode");
    step(1, OP_J,    0, 1, S_JUMP,   o_jump,     "j_jump");
    step(1, OP_ADDI, 0, 1, S_FETCH,  o_fetch_go, "addi_fetch");
    step(1, OP_ADDI, 0, 1, S_DECODE, o_decode,   "addi_decode");
    step(1, OP_ADDI, 0, 1, S_ADDIEX, o_addiex,   "addi_ex");
    step(1, OP_ADDI, 0, 1, S_ADDIWB, o_addiwb,   "addi_wb");
    step(1, OP_R,    0, 1, S_FETCH,  o_fetch_go, "r_fetch");
    step(1, OP_R,    0, 1, S_DECODE, o_decode,   "r_decode");
    step(1, OP_R,    0, 1, S_EXEC,   o_exec,     "r_exec");
    step(1, OP_R,    0, 1, S_ALUWB,  o_aluwb,    "r_aluwb");
    step(1, OP_R,    0, 0, S_FETCH,  o_fetch_st, "final_fetch");

    @(posedge clk);
    #1;
    checks++;
    if (exp_st_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending entries, expected 0", exp_st_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
